// File: rtl/modulo_pc_pkg.sv
// Shared PC definitions: default address width, reset PC, stack sizing helper and PC action decode.
// Imported by the PC register, the return stack and the neighbouring fetch logic.
package modulo_pc_pkg;

    localparam int ADDR_WIDTH_PAD = 13;
    localparam int PC_RESET_PAD   = 0;
    localparam int PILHA_PROF_PAD = 8;

    typedef enum logic [2:0] {
        ACAO_SEGURA,
        ACAO_PARA,
        ACAO_SEGUE,
        ACAO_RETORNA,
        ACAO_CHAMA
    } acao_e;

    // One extra bit so "full" (pointer == depth) is distinct from "empty".
    function automatic int largura_ptr(input int prof);
        return $clog2(prof) + 1;
    endfunction

endpackage

// File: rtl/modulo_pc_pilha_retorno.sv
// Return-address LIFO with a combinational top; pop beats push in the same cycle.
// Push on full and pop on empty are silently ignored.
module pilha_retorno
    import modulo_pc_pkg::*;
#(
    parameter int LARGURA = ADDR_WIDTH_PAD,
    parameter int PROF    = PILHA_PROF_PAD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [LARGURA-1:0] dado,
    output logic [LARGURA-1:0] topo,
    output logic               vazia,
    output logic               cheia
);

    localparam int PW = largura_ptr(PROF);

    logic [PW-1:0]      ptr_q, ptr_d;
    logic [LARGURA-1:0] mem_q [PROF];
    logic [PW-2:0]      idx_push, idx_topo;
    logic               pop_ok, push_ok;

    assign vazia    = (ptr_q == '0);
    assign cheia    = (ptr_q == PW'(PROF));
    assign idx_push = ptr_q[PW-2:0];
    assign idx_topo = idx_push - (PW-1)'(1);
    assign topo     = mem_q[idx_topo];
    assign pop_ok   = pop && !vazia;
    assign push_ok  = push && !pop && !cheia;

    always_comb begin
        ptr_d = ptr_q;
        if (pop_ok) begin
            ptr_d = ptr_q - PW'(1);
        end else if (push_ok) begin
            ptr_d = ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[idx_push] <= dado;
        end
    end

endmodule

// File: rtl/modulo_pc.sv
// Program counter with stall, sticky halt and hardware call/return stack; one-cycle registered output.
// Optional PC_PILHA_ERRO_EN adds a sticky erro_pilha flag that halts the PC after a stack over/underflow.
module modulo_pc
    import modulo_pc_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_PAD,
    parameter int PILHA_PROF = PILHA_PROF_PAD,
    parameter int PC_RESET   = PC_RESET_PAD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] novo_endereco,
    input  logic                  habilita,
    input  logic                  chamada,
    input  logic                  retorno,
    input  logic                  halt,
    output logic [ADDR_WIDTH-1:0] pc_atual,
`ifdef PC_PILHA_ERRO_EN
    output logic                  erro_pilha,
`endif
    output logic                  parado,
    output logic                  pilha_vazia,
    output logic                  pilha_cheia
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  parado_q, parado_d;
    logic [ADDR_WIDTH-1:0] topo;
    logic                  erro_ativo;
    acao_e                 acao;

`ifdef PC_PILHA_ERRO_EN
    logic erro_q, erro_d;

    // Only accepted cycles can raise the error; underflow decodes as SEGUE with retorno set.
    assign erro_d     = erro_q || (acao == ACAO_SEGUE && retorno)
                               || (acao == ACAO_CHAMA && pilha_cheia);
    assign erro_ativo = erro_q;
    assign erro_pilha = erro_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            erro_q <= 1'b0;
        end else begin
            erro_q <= erro_d;
        end
    end
`else
    assign erro_ativo = 1'b0;
`endif

    always_comb begin
        acao = ACAO_SEGURA;
        if (parado_q) begin
            acao = ACAO_SEGURA;
        end else if (halt || erro_ativo) begin
            acao = ACAO_PARA;
        end else if (!habilita) begin
            acao = ACAO_SEGURA;
        end else if (retorno) begin
            acao = pilha_vazia ? ACAO_SEGUE : ACAO_RETORNA;
        end else if (chamada) begin
            acao = ACAO_CHAMA;
        end else begin
            acao = ACAO_SEGUE;
        end
    end

    always_comb begin
        pc_d     = pc_q;
        parado_d = parado_q;
        case (acao)
            ACAO_PARA:               parado_d = 1'b1;
            ACAO_RETORNA:            pc_d     = topo;
            ACAO_SEGUE, ACAO_CHAMA:  pc_d     = novo_endereco;
            default:                 pc_d     = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= ADDR_WIDTH'(PC_RESET);
            parado_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            parado_q <= parado_d;
        end
    end

    pilha_retorno #(
        .LARGURA (ADDR_WIDTH),
        .PROF    (PILHA_PROF)
    ) u_pilha (
        .clk   (clk),
        .rst   (rst),
        .push  (acao == ACAO_CHAMA),
        .pop   (acao == ACAO_RETORNA),
        .dado  (pc_q + ADDR_WIDTH'(1)),
        .topo  (topo),
        .vazia (pilha_vazia),
        .cheia (pilha_cheia)
    );

    assign pc_atual = pc_q;
    assign parado   = parado_q;

endmodule

// File: tb/tb_modulo_pc.sv
// Scoreboarded bench for modulo_pc: directed scenarios then random traffic against a queue-based model.
module tb_modulo_pc;

    localparam int AW       = 13;
    localparam int PROF     = 8;
    localparam int PC_RST   = 0;
`ifdef PC_PILHA_ERRO_EN
    localparam bit ERRO_EN  = 1'b1;
`else
    localparam bit ERRO_EN  = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] novo_endereco = '0;
    logic          habilita = 1'b0;
    logic          chamada  = 1'b0;
    logic          retorno  = 1'b0;
    logic          halt     = 1'b0;
    logic [AW-1:0] pc_atual;
    logic          parado, pilha_vazia, pilha_cheia;
`ifdef PC_PILHA_ERRO_EN
    logic          erro_pilha;
`endif

    always #5 clk = ~clk;

    modulo_pc #(
        .ADDR_WIDTH (AW),
        .PILHA_PROF (PROF),
        .PC_RESET   (PC_RST)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .novo_endereco (novo_endereco),
        .habilita      (habilita),
        .chamada       (chamada),
        .retorno       (retorno),
        .halt          (halt),
        .pc_atual      (pc_atual),
`ifdef PC_PILHA_ERRO_EN
        .erro_pilha    (erro_pilha),
`endif
        .parado        (parado),
        .pilha_vazia   (pilha_vazia),
        .pilha_cheia   (pilha_cheia)
    );

    typedef struct {
        int pc;
        bit parado;
        bit vazia;
        bit cheia;
        bit erro;
    } esp_t;

    esp_t fila[$];
    int   m_pc     = PC_RST;
    bit   m_parado = 1'b0;
    bit   m_erro   = 1'b0;
    int   m_pilha[$];
    int   checks   = 0;
    int   errors   = 0;

    task automatic checa(input string nome, input int atual, input int esperado);
        checks++;
        if (atual != esperado) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nome, atual, esperado, $time);
        end
    endtask

    // Reference model: architectural state as plain integers and a queue used as the stack.
    task automatic modelo(input bit r, input bit h, input bit c, input bit ret, input bit hl, input int novo);
        if (r) begin
            m_pc = PC_RST;
            m_parado = 1'b0;
            m_erro = 1'b0;
            m_pilha.delete();
        end else if (m_parado) begin
            m_pc = m_pc;
        end else if (hl || (ERRO_EN && m_erro)) begin
            m_parado = 1'b1;
        end else if (h) begin
            if (ret) begin
                if (m_pilha.size() > 0) begin
                    m_pc = m_pilha.pop_back();
                end else begin
                    m_pc = novo;
                    m_erro = ERRO_EN;
                end
            end else if (c) begin
                if (m_pilha.size() < PROF) m_pilha.push_back((m_pc + 1) % (1 << AW));
                else m_erro = ERRO_EN;
                m_pc = novo;
            end else begin
                m_pc = novo;
            end
        end
    endtask

    task automatic passo(input bit r, input bit h, input bit c, input bit ret, input bit hl, input int novo);
        esp_t e;
        logic [AW-1:0] novo_v;
        novo_v = novo[AW-1:0];
        rst = r; habilita = h; chamada = c; retorno = ret; halt = hl;
        novo_endereco = novo_v;
        @(posedge clk);
        modelo(r, h, c, ret, hl, int'(novo_v));
        e.pc = m_pc;
        e.parado = m_parado;
        e.vazia = (m_pilha.size() == 0);
        e.cheia = (m_pilha.size() == PROF);
        e.erro = m_erro;
        fila.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        if (fila.size() > 0) begin
            esp_t e;
            e = fila.pop_front();
            checa("pc_atual", int'(pc_atual), e.pc);
            checa("parado", int'(parado), int'(e.parado));
            checa("pilha_vazia", int'(pilha_vazia), int'(e.vazia));
            checa("pilha_cheia", int'(pilha_cheia), int'(e.cheia));
`ifdef PC_PILHA_ERRO_EN
            checa("erro_pilha", int'(erro_pilha), int'(e.erro));
`endif
        end
    end

    initial begin
        // Basic advance with one-cycle lag.
        passo(1, 0, 0, 0, 0, 0);
        passo(0, 1, 0, 0, 0, 5);
        passo(0, 1, 0, 0, 0, 6);
        passo(0, 1, 0, 0, 0, 7);

        // Single call then return.
        passo(1, 0, 0, 0, 0, 0);
        passo(0, 1, 0, 0, 0, 'h10);
        passo(0, 1, 1, 0, 0, 'h40);
        passo(0, 1, 0, 1, 0, 'h99);

        // Fill past depth, then unwind past empty.
        passo(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < PROF + 1; i++) passo(0, 1, 1, 0, 0, 'h100 + i * 3);
        for (int i = 0; i < PROF + 1; i++) passo(0, 1, 0, 1, 0, 'h200 + i);

        // Stall with chamada held.
        passo(1, 0, 0, 0, 0, 0);
        passo(0, 1, 0, 0, 0, 'h30);
        for (int i = 0; i < 3; i++) passo(0, 0, 1, 0, 0, $urandom);

        // Sticky halt, then reset releases it.
        passo(0, 1, 0, 0, 0, 'h22);
        passo(0, 0, 0, 0, 1, 'h55);
        for (int i = 0; i < 4; i++) passo(0, $urandom % 2, $urandom % 2, $urandom % 2, 0, $urandom);
        passo(1, 1, 1, 0, 1, 'h77);

        // Return-address wrap and simultaneous call+return.
        passo(0, 1, 0, 0, 0, 'h1FFF);
        passo(0, 1, 1, 0, 0, 'h50);
        passo(0, 1, 1, 1, 0, 'h60);

        for (int i = 0; i < 3000; i++) begin
            bit r;
            r = m_parado ? ($urandom % 4 == 0) : ($urandom % 200 == 0);
            passo(r, $urandom % 5 != 0, $urandom % 3 == 0, $urandom % 3 == 0,
                  $urandom % 60 == 0, $urandom);
        end

        @(negedge clk);
        #1;
        checa("scoreboard_drained", fila.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
